a2d_intf: RTL and testbench

Master-side interface to the 12-bit A2D converter on the Segway board, sitting directly upstream of the A2D over its 4-wire SPI bus. On each `nxt` request it runs one conversion on the next channel of a fixed round-robin: channel 0 for left load cell, 4 for right load cell, 5 for battery. Each conversion is a two-transaction SPI exchange. The 12-bit result is captured into the matching holding register, and `cnv_cmplt` is pulsed for the balance and steering logic.

---
 rtl/a2d_intf.sv | 180 ++++++++++++++++++
 tb/tb_a2d_intf.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_intf.sv
// a2d_intf: round-robin SPI master for the Segway 12-bit A2D (channels 0, 4, 5).
// Define A2D_BATT_EN to convert the battery channel; otherwise batt reads full scale.
module a2d_intf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        cnv_cmplt
);
    localparam int unsigned DIV_W  = 5;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned RES_W  = 12;
    localparam int unsigned CH_W   = 3;
    localparam int unsigned PTR_W  = 2;

    localparam logic [DIV_W-1:0] DIV_START  = 5'b10111;
    localparam logic [DIV_W-1:0] DIV_RISE   = 5'b01111;
    localparam logic [DIV_W-1:0] DIV_FALL   = 5'b11111;
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] DONE_CNT   = CNT_W'(WORD_W);

    typedef enum logic [2:0] {IDLE, TX1, GAP, TX2, CAPT} state_t;

    state_t              state, state_nxt;
    logic [DIV_W-1:0]    div;
    logic [DIV_W-1:0]    div_inc;
    logic [WORD_W-1:0]   shft;
    logic [CNT_W-1:0]    shft_cnt;
    logic                first_fall;
    logic                miso_q;
    logic                nxt_q;
    logic                gap_seen;
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    ptr_nxt_c;
    logic [CH_W-1:0]     ch_c;
    logic [WORD_W-1:0]   cmd_c;
    logic                start_c;
    logic                capt_c;
    logic                done_c;

    assign div_inc = div + DIV_W'(1);
    assign done_c  = ~SS_n && (shft_cnt == DONE_CNT);
    assign MOSI    = shft[WORD_W-1];

    // Channel pointer to A2D channel number and command word
    always_comb begin
        ch_c      = CH_W'(0);
        ptr_nxt_c = PTR_W'(1);
        case (ptr)
            PTR_W'(1): begin
                ch_c = CH_W'(4);
`ifdef A2D_BATT_EN
                ptr_nxt_c = PTR_W'(2);
`else
                ptr_nxt_c = PTR_W'(0);
`endif
            end
            PTR_W'(2): begin
                ch_c      = CH_W'(5);
                ptr_nxt_c = PTR_W'(0);
            end
            default: ;
        endcase
        cmd_c = {2'b00, ch_c, 11'h000};
    end

    // SPI engine: first SCLK fall is a dummy, 16 shifts follow, SCLK held high after the last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SS_n       <= 1'b1;
            SCLK       <= 1'b1;
            div        <= '0;
            shft       <= '0;
            shft_cnt   <= '0;
            first_fall <= 1'b0;
            miso_q     <= 1'b0;
        end else if (start_c) begin
            SS_n       <= 1'b0;
            SCLK       <= 1'b1;
            div        <= DIV_START;
            shft       <= cmd_c;
            shft_cnt   <= '0;
            first_fall <= 1'b1;
        end else if (!SS_n) begin
            if (done_c) begin
                SS_n     <= 1'b1;
                SCLK     <= 1'b1;
                shft_cnt <= '0;
            end else begin
                if (div == DIV_RISE)
                    miso_q <= MISO;
                if (div == DIV_FALL && first_fall)
                    first_fall <= 1'b0;
                else if (div == DIV_FALL) begin
                    shft     <= {shft[WORD_W-2:0], miso_q};
                    shft_cnt <= shft_cnt + CNT_W'(1);
                end
                if (div == DIV_FALL && !first_fall && shft_cnt == LAST_SHIFT)
                    SCLK <= 1'b1;
                else begin
                    div  <= div_inc;
                    SCLK <= div_inc[DIV_W-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_c   = 1'b0;
        capt_c    = 1'b0;
        case (state)
            IDLE: if (nxt_q) begin
                start_c   = 1'b1;
                state_nxt = TX1;
            end
            TX1:  if (done_c) state_nxt = GAP;
            GAP:  if (gap_seen) begin
                start_c   = 1'b1;
                state_nxt = TX2;
            end
            TX2:  if (done_c) state_nxt = CAPT;
            CAPT: begin
                capt_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request sampling, gap timing, result capture and pointer advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nxt_q     <= 1'b0;
            gap_seen  <= 1'b0;
            ptr       <= '0;
            cnv_cmplt <= 1'b0;
            lft_ld    <= '0;
            rght_ld   <= '0;
        end else begin
            nxt_q     <= nxt;
            gap_seen  <= (state == GAP);
            cnv_cmplt <= capt_c;
            if (capt_c) begin
                ptr <= ptr_nxt_c;
                case (ptr)
                    PTR_W'(0): lft_ld  <= shft[RES_W-1:0];
                    PTR_W'(1): rght_ld <= shft[RES_W-1:0];
                    default: ;
                endcase
            end
        end
    end

`ifdef A2D_BATT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            batt <= '0;
        else if (capt_c && ptr == PTR_W'(2))
            batt <= shft[RES_W-1:0];
    end
`else
    assign batt = {RES_W{1'b1}};
`endif

endmodule

// File: tb/tb_a2d_intf.sv
// tb_a2d_intf: directed bench for a2d_intf with a behavioural A2D slave.
// Expectations follow A2D_BATT_EN the same way the design does.
module tb_a2d_intf;
`ifdef A2D_BATT_EN
    localparam bit BATT_EN = 1'b1;
`else
    localparam bit BATT_EN = 1'b0;
`endif
    localparam logic [11:0] BATT_RST = BATT_EN ? 12'h000 : 12'hFFF;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        nxt   = 1'b0;
    logic        MISO  = 1'b0;
    logic        SS_n, SCLK, MOSI, cnv_cmplt;
    logic [11:0] lft_ld, rght_ld, batt;

    int n_cmp = 0;
    int n_err = 0;

    a2d_intf dut (
        .clk(clk), .rst_n(rst_n), .nxt(nxt), .MISO(MISO),
        .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .lft_ld(lft_ld), .rght_ld(rght_ld), .batt(batt), .cnv_cmplt(cnv_cmplt)
    );

    always #5 clk = ~clk;

    // A2D slave: shifts data out on SCLK fall (first fall is a dummy), samples MOSI on rise
    logic [11:0] mem [8];
    logic [15:0] s_tx = '0;
    logic [15:0] s_rx = '0;
    logic [2:0]  s_ch = '0;
    int          s_rises = 0;
    int          s_falls = 0;
    logic        ss_p = 1'b1;
    logic        sc_p = 1'b1;
    logic [15:0] cmd_q [$];

    always @(SS_n or SCLK) begin
        if (ss_p && !SS_n) begin
            s_tx    = {4'hC, mem[s_ch]};
            MISO    = s_tx[15];
            s_rises = 0;
            s_falls = 0;
        end else if (!ss_p && SS_n) begin
            if (s_rises == 16) begin
                cmd_q.push_back(s_rx);
                s_ch = s_rx[13:11];
            end
        end else if (!SS_n && !sc_p && SCLK) begin
            s_rx = {s_rx[14:0], MOSI};
            s_rises++;
        end else if (!SS_n && sc_p && !SCLK) begin
            if (s_falls > 0) begin
                s_tx = {s_tx[14:0], 1'b0};
                MISO = s_tx[15];
            end
            s_falls++;
        end
        ss_p = SS_n;
        sc_p = SCLK;
    end

    // Waveform monitor: SS_n low/high run lengths, transaction and pulse counts
    logic mon_ss   = 1'b1;
    int   run      = 0;
    int   n_tx     = 0;
    int   n_cnv    = 0;
    int   sclk_bad = 0;
    int   low_q [$];
    int   hi_q [$];

    always @(negedge clk) begin
        if (SS_n !== mon_ss) begin
            if (SS_n) low_q.push_back(run);
            else begin
                hi_q.push_back(run);
                n_tx++;
            end
            run = 0;
        end
        run++;
        mon_ss = SS_n;
        if (cnv_cmplt) n_cnv++;
        if (SS_n && !SCLK) sclk_bad++;
    end

    int          m_ptr;
    logic [11:0] exp_l, exp_r, exp_b;

    function automatic logic [2:0] ch_of(input int p);
        case (p)
            1:       return 3'd4;
            2:       return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic int ptr_next(input int p);
        if (BATT_EN) return (p == 2) ? 0 : p + 1;
        return (p == 1) ? 0 : 1;
    endfunction

    function automatic logic [15:0] cmd_of(input logic [2:0] ch);
        case (ch)
            3'd4:    return 16'h2000;
            3'd5:    return 16'h2800;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        exp_l = 12'h000;
        exp_r = 12'h000;
        exp_b = BATT_RST;
    endtask

    task automatic model_capture(input logic [2:0] ch);
        case (ch)
            3'd0: exp_l = mem[0];
            3'd4: exp_r = mem[4];
            3'd5: exp_b = BATT_EN ? mem[5] : 12'hFFF;
            default: ;
        endcase
    endtask

    task automatic check_regs(input string tag);
        check_eq({tag, " lft_ld"},  32'(lft_ld),  32'(exp_l));
        check_eq({tag, " rght_ld"}, 32'(rght_ld), 32'(exp_r));
        check_eq({tag, " batt"},    32'(batt),    32'(exp_b));
    endtask

    task automatic check_spi(input string tag, input logic [2:0] ch,
                             input int lo0, input int hi0, input int q0);
        check_eq({tag, " cmd count"}, 32'(cmd_q.size() - q0), 32'd2);
        if (cmd_q.size() >= q0 + 2) begin
            check_eq({tag, " cmd1"}, 32'(cmd_q[q0]),     32'(cmd_of(ch)));
            check_eq({tag, " cmd2"}, 32'(cmd_q[q0 + 1]), 32'(cmd_of(ch)));
        end
        check_eq({tag, " low runs"}, 32'(low_q.size() - lo0), 32'd2);
        if (low_q.size() >= lo0 + 2) begin
            check_eq({tag, " tx1 low"}, 32'(low_q[lo0]),     32'd522);
            check_eq({tag, " tx2 low"}, 32'(low_q[lo0 + 1]), 32'd522);
        end
        if (hi_q.size() >= hi0 + 2)
            check_eq({tag, " gap"}, 32'(hi_q[hi0 + 1]), 32'd2);
        else
            check_eq({tag, " gap runs"}, 32'(hi_q.size() - hi0), 32'd2);
    endtask

    task automatic pulse_nxt();
        @(negedge clk) nxt = 1'b1;
        @(posedge clk);
        #1;
        nxt = 1'b0;
    endtask

    task automatic wait_ss(input logic val, input string tag);
        int k = 0;
        while (SS_n !== val && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, " SS_n wait"}, 32'(SS_n), 32'(val));
    endtask

    task automatic conv_and_check(input string tag);
        logic [2:0] ch;
        int lat, lo0, hi0, q0, c0;
        ch  = ch_of(m_ptr);
        lo0 = low_q.size();
        hi0 = hi_q.size();
        q0  = cmd_q.size();
        c0  = n_cnv;
        pulse_nxt();
        lat = 0;
        while (lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
            if (cnv_cmplt) break;
        end
        check_eq({tag, " latency"}, 32'(lat), 32'd1048);
        model_capture(ch);
        check_regs(tag);
        @(posedge clk);
        #1;
        check_eq({tag, " pulse width"}, 32'(cnv_cmplt), 32'd0);
        check_eq({tag, " pulse count"}, 32'(n_cnv - c0), 32'd1);
        check_spi(tag, ch, lo0, hi0, q0);
        m_ptr = ptr_next(m_ptr);
    endtask

    task automatic apply_reset();
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin : main
        int          c0, t0, lo0, hi0, q0, k;
        logic [2:0]  ch;
        for (int i = 0; i < 8; i++) mem[i] = 12'h000;
        model_reset();

        // Reset values, then quiet idle
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst SS_n", 32'(SS_n), 32'd1);
        check_eq("rst SCLK", 32'(SCLK), 32'd1);
        check_eq("rst MOSI", 32'(MOSI), 32'd0);
        check_eq("rst cnv_cmplt", 32'(cnv_cmplt), 32'd0);
        check_regs("rst");
        @(negedge clk) rst_n = 1'b1;
        t0 = n_tx;
        repeat (100) @(posedge clk);
        #1;
        check_eq("idle transactions", 32'(n_tx - t0), 32'd0);
        check_eq("idle SS_n", 32'(SS_n), 32'd1);
        check_eq("idle SCLK", 32'(SCLK), 32'd1);
        check_eq("idle cnv count", 32'(n_cnv), 32'd0);

        // Single conversion on channel 0
        mem[0] = 12'h3A5;
        conv_and_check("single");
        check_eq("single lft value", 32'(lft_ld), 32'h3A5);

        // Round-robin with wrap back to channel 0
        apply_reset();
        mem[0] = 12'h111;
        mem[4] = 12'h222;
        mem[5] = 12'h333;
        conv_and_check("rr0");
        conv_and_check("rr1");
        conv_and_check("rr2");
        conv_and_check("rr3");

        // nxt during TX1 and during GAP is dropped
        ch  = ch_of(m_ptr);
        lo0 = low_q.size();
        hi0 = hi_q.size();
        q0  = cmd_q.size();
        c0  = n_cnv;
        t0  = n_tx;
        mem[ch] = 12'h5C3;
        pulse_nxt();
        repeat (100) @(posedge clk);
        #1 nxt = 1'b1;
        @(posedge clk);
        #1 nxt = 1'b0;
        wait_ss(1'b1, "ign tx1 end");
        nxt = 1'b1;
        @(posedge clk);
        #1 nxt = 1'b0;
        k = 0;
        while (!cnv_cmplt && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("ign done", 32'(cnv_cmplt), 32'd1);
        model_capture(ch);
        check_regs("ign");
        repeat (1200) @(posedge clk);
        #1;
        check_eq("ign cnv count", 32'(n_cnv - c0), 32'd1);
        check_eq("ign tx count", 32'(n_tx - t0), 32'd2);
        check_spi("ign", ch, lo0, hi0, q0);
        m_ptr = ptr_next(m_ptr);

        // Reset in the middle of TX2 of a channel-4 conversion
        apply_reset();
        mem[0] = 12'h0A7;
        mem[4] = 12'h6B4;
        conv_and_check("pre-rst");
        c0 = n_cnv;
        pulse_nxt();
        wait_ss(1'b0, "mid tx1");
        wait_ss(1'b1, "mid gap");
        wait_ss(1'b0, "mid tx2");
        repeat (200) @(negedge clk);
        k = 0;
        while (SCLK !== 1'b0 && k < 64) begin
            @(negedge clk);
            k++;
        end
        check_eq("mid SCLK low", 32'(SCLK), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid rst SS_n", 32'(SS_n), 32'd1);
        check_eq("mid rst SCLK", 32'(SCLK), 32'd1);
        check_eq("mid rst MOSI", 32'(MOSI), 32'd0);
        model_reset();
        check_regs("mid rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (1200) @(posedge clk);
        #1;
        check_eq("mid rst no capture", 32'(n_cnv - c0), 32'd0);
        check_regs("mid rst idle");
        conv_and_check("post-rst");
        check_eq("post-rst lft value", 32'(lft_ld), 32'h0A7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
